imem_loader: RTL and testbench

Byte-stream program loader that writes the fetch stage's byte-addressed instruction memory. It receives framed bytes over a valid/ready handshake and assembles them into big-endian 32-bit words, so the byte at address a holds word bits [31:24]. It writes each word through a single write port, holds the fetch stage frozen while loading, and pulses a PC restart on a good load. It is the writer side of the instruction memory that IF reads as {mem[PC], mem[PC+1], mem[PC+2], mem[PC+3]}.

---
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader that fills the instruction memory with big-endian words and restarts the core.
// Latency: the word write strobe is registered at the edge that accepts the 4th byte; pc_reset follows the checksum edge.
// Backpressure: in_ready drops only in the single-cycle FIN/ERR states; in_valid gaps stall the FSM without a timeout.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              pc_reset,
    output logic              done,
    output logic              err
);

    if (MAX_WORDS * 4 > 2 ** ADDR_W) begin : g_bad_param
        $error("imem_loader: MAX_WORDS words do not fit in 2**ADDR_W bytes");
    end

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_FIN,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              pcr_q, pcr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic accept;
    logic len_bad;

    // Ready is decoded from the state register only, so no input reaches an output combinationally.
    assign in_ready = (state_q != S_FIN) && (state_q != S_ERR);
    assign accept   = in_valid && in_ready;
    assign len_bad  = (in_data == 8'd0) || (32'(in_data) > MAX_WORDS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            bcnt_q  <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            pcr_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            pcr_q   <= pcr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        pcr_d   = 1'b0;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept && in_data == HDR_BYTE) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    csum_d  = '0;
                    addr_d  = '0;
                    bcnt_d  = '0;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        cnt_d   = in_data;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d = {word_q[15:0], in_data};
                    csum_d = csum_q + in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = {word_q, in_data};
                        addr_d  = addr_q + ADDR_W'(4);
                        cnt_d   = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        pcr_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_FIN: begin
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            // A rejected frame keeps the core frozen; partially written words stay in memory.
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_we    = we_q;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign core_hold = hold_q;
    assign pc_reset  = pcr_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-frame bench for imem_loader with a queue scoreboard checked by a negedge monitor.
module tb_imem_loader;
    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              pc_reset;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .pc_reset (pc_reset),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic              is_pc;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    logic prev_we = 1'b0;

    logic [31:0] GOOD_W [2] = '{32'hE3A00014, 32'hE3A01A01};
    logic [7:0]  good[$]    = '{8'hA5, 8'h02, 8'hE3, 8'hA0, 8'h00, 8'h14,
                                8'hE3, 8'hA0, 8'h1A, 8'h01, 8'h35};
    logic [7:0]  bad[$];
    logic [7:0]  partial[$];
    logic [7:0]  len0[$]    = '{8'hA5, 8'h00};
    logic [7:0]  len65[$]   = '{8'hA5, 8'h41};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            chk("we_not_adjacent", {31'd0, prev_we}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("ev_kind_write", {31'd0, mon_ev.is_pc}, 0);
                chk("wr_addr", {24'd0, mem_addr}, {24'd0, mon_ev.addr});
                chk("wr_data", mem_wdata, mon_ev.data);
            end
        end
        if (pc_reset) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pc_reset", 1, 0);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("ev_kind_pc_reset", {31'd0, mon_ev.is_pc}, 1);
            end
        end
        prev_we = mem_we;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !sent; t++) begin
            if (in_ready) sent = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!sent) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int gap, input int nwr);
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i]);
            if (i == 0) chk("hold_rise_at_header", {31'd0, core_hold}, 1);
            if (i >= 2 && (i - 2) % 4 == 3 && (i - 2) / 4 < nwr) begin
                exp_q.push_back('{1'b0, ADDR_W'(((i - 2) / 4) * 4), GOOD_W[(i - 2) / 4]});
                chk("we_after_4th_byte", {31'd0, mem_we}, 1);
            end
            if (i < fr.size() - 1) idle(gap);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_core_hold", {31'd0, core_hold}, 0);
        chk("rst_pc_reset", {31'd0, pc_reset}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
    endtask

    task automatic good_frame(input int gap);
        send_frame(good, gap, 2);
        exp_q.push_back('{1'b1, ADDR_W'(0), 32'd0});
        chk("good_pc_reset", {31'd0, pc_reset}, 1);
        chk("good_done", {31'd0, done}, 1);
        chk("good_err", {31'd0, err}, 0);
        chk("good_hold_in_fin", {31'd0, core_hold}, 1);
        chk("good_fin_not_ready", {31'd0, in_ready}, 0);
        idle(1);
        chk("good_pc_reset_drop", {31'd0, pc_reset}, 0);
        chk("good_hold_drop", {31'd0, core_hold}, 0);
        chk("good_done_sticky", {31'd0, done}, 1);
        chk("good_ready_back", {31'd0, in_ready}, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bad = good;
        bad[10] = 8'h36;
        for (int i = 0; i < 8; i++) partial.push_back(good[i]);

        idle(3);
        chk_reset_vals();
        rst = 1'b1;
        idle(2);
        chk("pre_hold", {31'd0, core_hold}, 0);

        good_frame(0);

        send_frame(bad, 0, 2);
        chk("bad_err", {31'd0, err}, 1);
        chk("bad_no_pc_reset", {31'd0, pc_reset}, 0);
        chk("bad_done", {31'd0, done}, 0);
        chk("bad_hold", {31'd0, core_hold}, 1);
        chk("bad_err_not_ready", {31'd0, in_ready}, 0);
        idle(4);
        chk("bad_err_sticky", {31'd0, err}, 1);
        chk("bad_hold_kept", {31'd0, core_hold}, 1);
        good_frame(0);

        send_frame(len0, 0, 0);
        chk("len0_err", {31'd0, err}, 1);
        chk("len0_hold", {31'd0, core_hold}, 1);
        chk("len0_in_err_state", {31'd0, in_ready}, 0);
        chk("len0_done", {31'd0, done}, 0);
        idle(2);
        send_frame(len65, 0, 0);
        chk("len65_err", {31'd0, err}, 1);
        chk("len65_hold", {31'd0, core_hold}, 1);
        chk("len65_in_err_state", {31'd0, in_ready}, 0);
        idle(2);

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        chk("garbage_err_kept", {31'd0, err}, 1);
        chk("garbage_hold_kept", {31'd0, core_hold}, 1);
        good_frame(3);

        send_frame(partial, 0, 1);
        chk("partial_hold", {31'd0, core_hold}, 1);
        rst = 1'b0;
        #1;
        chk_reset_vals();
        idle(2);
        rst = 1'b1;
        idle(4);
        chk_reset_vals();
        chk("partial_no_pending", exp_q.size(), 0);
        good_frame(0);

        idle(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
